// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl shared types and defaults.
// State encoding and default widths for the layer controller.
package conv_ctrl_pkg;

  localparam int DATA_SIZE_DEF  = 16;
  localparam int LOOP_BIT_DEF   = 8;
  localparam int PIPE_DEPTH_DEF = 4;
  localparam int NLEV           = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/conv_ctrl_idx.sv
// Six cascaded wrap counters for the conv loop nest.
// Level 0 is jj (innermost), level 5 is rr (outermost).
module conv_ctrl_idx
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int LOOP_BIT  = LOOP_BIT_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                en,
  input  logic [NLEV-1:0][DATA_SIZE-1:0]      lim,
  output logic [NLEV-1:0][LOOP_BIT-1:0]       idx,
  output logic [NLEV-1:0]                     last,
  output logic                                all_last
);

  logic [NLEV-1:0] step;

  // per-level wrap detect and carry chain
  always_comb begin
    last = '0;
    step = '0;
    for (int k = 0; k < NLEV; k++) begin
      last[k] = (DATA_SIZE'(idx[k]) == lim[k]);
    end
    step[0] = en;
    for (int k = 1; k < NLEV; k++) begin
      step[k] = step[k-1] & last[k-1];
    end
  end

  assign all_last = &last;

  // advance or wrap each level when its carry arrives
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else begin
      for (int k = 0; k < NLEV; k++) begin
        if (step[k]) begin
          idx[k] <= last[k] ? '0 : idx[k] + LOOP_BIT'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Layer-level controller for the conv datapath.
// Validates config, steps the loop nest, drains the PE pipe.
module conv_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int LOOP_BIT   = LOOP_BIT_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] cfg_R,
  input  logic [DATA_SIZE-1:0] cfg_C,
  input  logic [DATA_SIZE-1:0] cfg_M,
  input  logic [DATA_SIZE-1:0] cfg_N,
  input  logic [DATA_SIZE-1:0] cfg_K,
  input  logic                 buf_ready,
  input  logic                 pe_ready,
  output logic                 busy,
  output logic                 loop_en,
  output logic [LOOP_BIT-1:0]  rr,
  output logic [LOOP_BIT-1:0]  cc,
  output logic [LOOP_BIT-1:0]  mm,
  output logic [LOOP_BIT-1:0]  nn,
  output logic [LOOP_BIT-1:0]  ii,
  output logic [LOOP_BIT-1:0]  jj,
  output logic                 acc_clr,
  output logic                 acc_last,
  output logic                 done,
  output logic                 cfg_err,
  output logic [31:0]          run_cycles
);

  localparam int CW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DATA_SIZE:0] MAXB =
    (DATA_SIZE+1)'(1) << LOOP_BIT;

  state_t                          state;
  logic [NLEV-1:0][DATA_SIZE-1:0]  lim;
  logic [NLEV-1:0][LOOP_BIT-1:0]   idx;
  logic [NLEV-1:0]                 lvl_last;
  logic                            all_last;
  logic                            cfg_ok;
  logic                            accept;
  logic [CW-1:0]                   dcnt;
  logic                            unused_last;

  function automatic logic fld_ok(
    input logic [DATA_SIZE-1:0] f
  );
    return (f != '0) && ({1'b0, f} <= MAXB);
  endfunction

  assign cfg_ok = fld_ok(cfg_R) & fld_ok(cfg_C) &
                  fld_ok(cfg_M) & fld_ok(cfg_N) &
                  fld_ok(cfg_K);

  assign accept  = (state == IDLE) & start & cfg_ok;
  assign loop_en = (state == RUN) & pe_ready;

  assign acc_clr  = loop_en & (idx[2] == '0) &
                    (idx[1] == '0) & (idx[0] == '0);
  assign acc_last = loop_en & (&lvl_last[2:0]);

  assign unused_last = ^lvl_last[5:3];

  assign jj = idx[0];
  assign ii = idx[1];
  assign nn = idx[2];
  assign mm = idx[3];
  assign cc = idx[4];
  assign rr = idx[5];

  conv_ctrl_idx #(
    .DATA_SIZE (DATA_SIZE),
    .LOOP_BIT  (LOOP_BIT)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (loop_en),
    .lim      (lim),
    .idx      (idx),
    .last     (lvl_last),
    .all_last (all_last)
  );

  // layer FSM with registered status strobes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lim        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      dcnt       <= '0;
      run_cycles <= '0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              lim[0]     <= cfg_K - DATA_SIZE'(1);
              lim[1]     <= cfg_K - DATA_SIZE'(1);
              lim[2]     <= cfg_N - DATA_SIZE'(1);
              lim[3]     <= cfg_M - DATA_SIZE'(1);
              lim[4]     <= cfg_C - DATA_SIZE'(1);
              lim[5]     <= cfg_R - DATA_SIZE'(1);
              run_cycles <= '0;
              busy       <= 1'b1;
              state      <= LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (buf_ready) begin
            state <= RUN;
          end
        end
        RUN: begin
          run_cycles <= run_cycles + 32'd1;
          if (loop_en && all_last) begin
            dcnt  <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == CW'(PIPE_DEPTH - 1)) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl.
// Random stalls and stray starts against a loop-nest model.
module tb_conv_ctrl;

  localparam int DS = 16;
  localparam int LB = 8;
  localparam int PD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DS-1:0] cfg_R, cfg_C, cfg_M, cfg_N, cfg_K;
  logic          buf_ready;
  logic          pe_ready;
  logic          busy, loop_en, acc_clr, acc_last;
  logic          done, cfg_err;
  logic [LB-1:0] rr, cc, mm, nn, ii, jj;
  logic [31:0]   run_cycles;

  int checks   = 0;
  int failures = 0;
  int prev_run = 0;
  int tgt[6];

  typedef struct {
    int r; int c; int m; int n; int i; int j;
  } it_t;

  conv_ctrl #(
    .DATA_SIZE  (DS),
    .LOOP_BIT   (LB),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_R      (cfg_R),
    .cfg_C      (cfg_C),
    .cfg_M      (cfg_M),
    .cfg_N      (cfg_N),
    .cfg_K      (cfg_K),
    .buf_ready  (buf_ready),
    .pe_ready   (pe_ready),
    .busy       (busy),
    .loop_en    (loop_en),
    .rr         (rr),
    .cc         (cc),
    .mm         (mm),
    .nn         (nn),
    .ii         (ii),
    .jj         (jj),
    .acc_clr    (acc_clr),
    .acc_last   (acc_last),
    .done       (done),
    .cfg_err    (cfg_err),
    .run_cycles (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic idx_zero(input string tag);
    chk({tag, "_idx0"},
        longint'(rr) + cc + mm + nn + ii + jj, 0);
  endtask

  task automatic stray(input bit noise);
    start = noise && ($urandom_range(0, 3) == 0);
    cfg_R = DS'($urandom_range(0, 300));
    cfg_C = DS'($urandom_range(0, 3));
    cfg_M = DS'($urandom_range(0, 3));
    cfg_N = DS'($urandom_range(0, 3));
    cfg_K = DS'($urandom_range(0, 3));
  endtask

  task automatic run_layer(input int R, input int C,
                           input int M, input int N,
                           input int K, input int mode,
                           input bit noise, input bit abort);
    it_t q[$];
    it_t e;
    int runcnt = 0;
    int issues = 0;
    int clrs   = 0;
    int lasts  = 0;
    int lat;
    int budget;
    bit ph  = 1'b0;
    bit hit = 1'b0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        for (int m = 0; m < M; m++)
          for (int n = 0; n < N; n++)
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++)
                q.push_back('{r, c, m, n, i, j});
    // start cycle, DUT still idle
    @(posedge clk); #1;
    start = 1'b1;
    cfg_R = DS'(R); cfg_C = DS'(C); cfg_M = DS'(M);
    cfg_N = DS'(N); cfg_K = DS'(K);
    buf_ready = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_run_cycles", run_cycles, prev_run);
    // LOAD: buf_ready rises in the last LOAD cycle
    lat = $urandom_range(0, 3);
    for (int k = 0; k <= lat; k++) begin
      @(posedge clk); #1;
      stray(noise);
      pe_ready  = 1'($urandom_range(0, 1));
      buf_ready = (k == lat);
      @(negedge clk);
      chk("load_busy", busy, 1);
      chk("load_loop_en", loop_en, 0);
      chk("load_cfg_err", cfg_err, 0);
      idx_zero("load");
    end
    // RUN
    budget = 4 * q.size() + 50;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk); #1;
      stray(noise);
      buf_ready = 1'($urandom_range(0, 1));
      case (mode)
        0:       pe_ready = 1'b1;
        1:       pe_ready = ph;
        default: pe_ready = 1'($urandom_range(0, 1));
      endcase
      ph = ~ph;
      e = q[0];
      if (abort && e.r == tgt[0] && e.c == tgt[1] &&
          e.m == tgt[2] && e.n == tgt[3] &&
          e.i == tgt[4] && e.j == tgt[5])
        rst = 1'b0;
      @(negedge clk);
      runcnt++;
      budget--;
      chk("run_busy", busy, 1);
      chk("run_loop_en", loop_en, pe_ready);
      chk("run_rr", rr, e.r);
      chk("run_cc", cc, e.c);
      chk("run_mm", mm, e.m);
      chk("run_nn", nn, e.n);
      chk("run_ii", ii, e.i);
      chk("run_jj", jj, e.j);
      chk("run_acc_clr", acc_clr, pe_ready &&
          e.n == 0 && e.i == 0 && e.j == 0);
      chk("run_acc_last", acc_last, pe_ready &&
          e.n == N-1 && e.i == K-1 && e.j == K-1);
      chk("run_done", done, 0);
      chk("run_cfg_err", cfg_err, 0);
      issues += int'(loop_en);
      clrs   += int'(acc_clr);
      lasts  += int'(acc_last);
      if (pe_ready) void'(q.pop_front());
      if (!rst) begin
        hit = 1'b1;
        break;
      end
    end
    if (hit) begin
      @(posedge clk); #1;
      rst = 1'b1;
      start = 1'b0;
      pe_ready = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_loop_en", loop_en, 0);
      chk("rst_acc_clr", acc_clr, 0);
      chk("rst_run_cycles", run_cycles, 0);
      chk("rst_done", done, 0);
      idx_zero("rst");
      prev_run = 0;
      for (int k = 0; k < PD + 3; k++) begin
        @(negedge clk);
        chk("rst_no_done", done, 0);
        chk("rst_idle", busy, 0);
      end
      return;
    end
    chk("run_timeout", q.size(), 0);
    chk("loop_en_count", issues, R*C*M*N*K*K);
    chk("acc_clr_count", clrs, R*C*M);
    chk("acc_last_count", lasts, R*C*M);
    // DRAIN
    for (int k = 0; k < PD; k++) begin
      @(posedge clk); #1;
      stray(noise);
      pe_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("drain_busy", busy, 1);
      chk("drain_loop_en", loop_en, 0);
      chk("drain_done", done, 0);
      chk("drain_cfg_err", cfg_err, 0);
      chk("drain_run_cycles", run_cycles, runcnt);
      idx_zero("drain");
    end
    // FIN
    @(posedge clk); #1;
    stray(noise);
    @(negedge clk);
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_cfg_err", cfg_err, 0);
    chk("fin_run_cycles", run_cycles, runcnt);
    prev_run = runcnt;
  endtask

  task automatic bad_start(input int R, input int C,
                           input int M, input int N,
                           input int K);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_R = DS'(R); cfg_C = DS'(C); cfg_M = DS'(M);
    cfg_N = DS'(N); cfg_K = DS'(K);
    pe_ready  = 1'b1;
    buf_ready = 1'b1;
    @(negedge clk);
    chk("bad_idle_busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("bad_cfg_err", cfg_err, 1);
    chk("bad_busy", busy, 0);
    chk("bad_loop_en", loop_en, 0);
    chk("bad_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bad_cfg_err_gone", cfg_err, 0);
      chk("bad_busy_after", busy, 0);
      chk("bad_done_after", done, 0);
      chk("bad_run_cycles", run_cycles, prev_run);
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    buf_ready = 1'b0;
    pe_ready = 1'b0;
    cfg_R = '0; cfg_C = '0; cfg_M = '0;
    cfg_N = '0; cfg_K = '0;
    tgt = '{1, 0, 1, 0, 2, 1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_loop_en", loop_en, 0);
    chk("reset_acc_clr", acc_clr, 0);
    chk("reset_acc_last", acc_last, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_err", cfg_err, 0);
    chk("reset_run_cycles", run_cycles, 0);
    idx_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    run_layer(2, 2, 2, 2, 3, 0, 1'b0, 1'b0);
    run_layer(2, 2, 2, 2, 3, 1, 1'b0, 1'b0);
    chk("toggle_run_cycles", prev_run, 288);
    bad_start(2, 2, 2, 2, 0);
    bad_start(2, 2, 257, 2, 2);
    bad_start(0, 1, 1, 1, 1);
    run_layer(1, 1, 1, 1, 1, 0, 1'b0, 1'b0);
    run_layer(256, 1, 1, 1, 1, 2, 1'b0, 1'b0);
    run_layer(2, 2, 2, 2, 3, 0, 1'b0, 1'b1);
    run_layer(2, 2, 2, 2, 3, 2, 1'b0, 1'b0);
    run_layer(2, 2, 2, 2, 3, 2, 1'b1, 1'b0);
    for (int n = 0; n < 6; n++) begin
      run_layer($urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(1, 3),
                $urandom_range(1, 3), $urandom_range(0, 2),
                1'b1, 1'b0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("end_idle_busy", busy, 0);
    chk("end_run_cycles", run_cycles, prev_run);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
